// File: rtl/tcdm_pkg.sv
// rtl/tcdm_pkg.sv - response type and opcode constants shared by the TCDM bank adapter files
package tcdm_pkg;

  localparam int TCDM_DATA_WIDTH = 32;

  localparam logic TCDM_OPC_OK  = 1'b0;
  localparam logic TCDM_OPC_ERR = 1'b1;

  typedef struct packed {
    logic                       opc;
    logic [TCDM_DATA_WIDTH-1:0] rdata;
  } tcdm_rsp_t;

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// rtl/tcdm_rsp_fifo.sv - in-order response FIFO; pointers carry a wrap bit to tell full from empty
module tcdm_rsp_fifo
  import tcdm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        push_tvalid,
  output logic        push_tready,
  input  tcdm_rsp_t   push_tdata,
  output logic        pop_tvalid,
  input  logic        pop_tready,
  output tcdm_rsp_t   pop_tdata,
  output logic [AW:0] count
);

  tcdm_rsp_t   mem_q [DEPTH];
  tcdm_rsp_t   mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        empty, full, do_push, do_pop;

  // Wraps modulo DEPTH even when DEPTH is not a power of two.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    logic [AW:0] r;
    if (p[AW-1:0] == AW'(DEPTH - 1)) r = {~p[AW], {AW{1'b0}}};
    else                             r = p + (AW+1)'(1);
    return r;
  endfunction

  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_tvalid  = ~empty;
    pop_tdata   = mem_q[rptr_q[AW-1:0]];
    push_tready = ~full | pop_tready;
    do_push     = push_tvalid & push_tready;
    do_pop      = pop_tvalid & pop_tready;
    if (wptr_q[AW] == rptr_q[AW]) count = wptr_q - rptr_q;
    else count = (AW+1)'(DEPTH) + {1'b0, wptr_q[AW-1:0]} - {1'b0, rptr_q[AW-1:0]};
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_tdata;
      wptr_d                = ptr_inc(wptr_q);
    end
    if (do_pop) rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/tcdm_sram_bank_adapter.sv
// rtl/tcdm_sram_bank_adapter.sv - req/gnt + valid/ready port to active-low SRAM bank pins with credit-buffered responses
module tcdm_sram_bank_adapter
  import tcdm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 15,
  parameter int          DATA_WIDTH = TCDM_DATA_WIDTH,
  parameter int          BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS  = 28672,
  parameter int          RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH+1:0] add_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic                  CEN,
  output logic                  WEN,
  output logic [BE_WIDTH-1:0]   BEN,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int                  CW        = $clog2(RSP_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
  localparam logic [CW+1:0]       DEPTH_W   = (CW+2)'(RSP_DEPTH);

  logic          dly_vld_q, dly_vld_d, dly_rd_q, dly_rd_d, dly_opc_q, dly_opc_d;
  logic          in_range, grant, bank_en;
  logic [CW:0]   fifo_count;
  logic [CW+1:0] occ;
  logic          unused_push_tready, unused_add_lsb;
  tcdm_rsp_t     push_data, pop_data;

  assign unused_add_lsb = ^add_i[1:0];

  always_comb begin
    in_range = {1'b0, add_i[ADDR_WIDTH+1:2]} < MEM_LIMIT;
    // Credit counts the delay-register slot so a granted request always has FIFO room.
    occ      = {1'b0, fifo_count} + (CW+2)'(dly_vld_q);
    grant    = RSTN & req_i & ((occ < DEPTH_W) | (r_valid_o & r_ready_i));
    bank_en  = grant & in_range;
    gnt_o    = grant;
    CEN      = ~bank_en;
    WEN      = bank_en ? ~we_i : 1'b1;
    BEN      = ~be_i;
    A        = add_i[ADDR_WIDTH+1:2];
    D        = wdata_i;

    dly_vld_d = grant;
    dly_rd_d  = bank_en & ~we_i;
    dly_opc_d = (grant & ~in_range) ? TCDM_OPC_ERR : TCDM_OPC_OK;

    push_data.opc   = dly_opc_q;
    push_data.rdata = dly_rd_q ? Q : '0;
    r_rdata_o       = pop_data.rdata;
    r_opc_o         = pop_data.opc;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dly_vld_q <= 1'b0;
      dly_rd_q  <= 1'b0;
      dly_opc_q <= TCDM_OPC_OK;
    end else begin
      dly_vld_q <= dly_vld_d;
      dly_rd_q  <= dly_rd_d;
      dly_opc_q <= dly_opc_d;
    end
  end

  tcdm_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .push_tvalid (dly_vld_q),
    .push_tready (unused_push_tready),
    .push_tdata  (push_data),
    .pop_tvalid  (r_valid_o),
    .pop_tready  (r_ready_i),
    .pop_tdata   (pop_data),
    .count       (fifo_count)
  );

endmodule

// File: tb/tb_tcdm_sram_bank_adapter.sv
// tb/tb_tcdm_sram_bank_adapter.sv - directed bench with a 1-cycle-latency SRAM bank model
module tb_tcdm_sram_bank_adapter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        req_i, gnt_o, we_i;
  logic [16:0] add_i;
  logic [3:0]  be_i, BEN;
  logic [31:0] wdata_i, r_rdata_o, D;
  logic [31:0] Q = '0;
  logic        r_valid_o, r_ready_i, r_opc_o, CEN, WEN;
  logic [14:0] A;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int gcnt, k;
  logic [32:0] rsp_q [$];
  int          rsp_cyc [$];
  logic [31:0] mem [0:32767];

  always #5 CLK = ~CLK;

  tcdm_sram_bank_adapter dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .add_i     (add_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .wdata_i   (wdata_i),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .r_rdata_o (r_rdata_o),
    .r_opc_o   (r_opc_o),
    .CEN       (CEN),
    .WEN       (WEN),
    .BEN       (BEN),
    .A         (A),
    .D         (D),
    .Q         (Q)
  );

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) begin
        for (int b = 0; b < 4; b++)
          if (!BEN[b]) mem[A][8*b +: 8] <= D[8*b +: 8];
      end else begin
        Q <= mem[A];
      end
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (r_valid_o && r_ready_i) begin
      rsp_q.push_back({r_opc_o, r_rdata_o});
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [16:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    req_i = v; we_i = we; add_i = addr; be_i = be; wdata_i = wd;
  endtask

  task automatic wait_rsp(input int n);
    int w = 0;
    while (rsp_q.size() < n && w < 50) begin
      @(negedge CLK);
      w++;
    end
    repeat (3) @(negedge CLK);
    check("rsp_count", 64'(rsp_q.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    mem[28671] = 32'h600D_600D;
    RSTN = 1'b0;
    r_ready_i = 1'b1;
    drive(1, 0, 17'h0, 4'hF, 32'h0);

    // 1. reset with request pending
    repeat (3) @(negedge CLK);
    check("rst_gnt", gnt_o, 0);
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_rvalid", r_valid_o, 0);
    check("rst_rdata", r_rdata_o, 0);
    check("rst_opc", r_opc_o, 0);
    RSTN = 1'b1;
    #1;
    check("rst_first_gnt", gnt_o, 1);
    check("rst_first_cen", CEN, 0);
    @(posedge CLK); #1;
    req_i = 1'b0;
    wait_rsp(1);
    check("rst_first_rsp", rsp_q[0], {1'b0, 32'h0});

    // 2. write then read, in order, with latency
    rsp_q.delete(); rsp_cyc.delete();
    @(posedge CLK); #1;
    drive(1, 1, 17'h100, 4'b0011, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("wr_gnt", gnt_o, 1);
    check("wr_cen", CEN, 0);
    check("wr_wen", WEN, 0);
    check("wr_ben", BEN, 4'b1100);
    check("wr_a", A, 15'h40);
    check("wr_d", D, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    drive(1, 0, 17'h100, 4'hF, 32'h0);
    @(negedge CLK);
    check("rd_gnt", gnt_o, 1);
    check("rd_wen", WEN, 1);
    check("wr_latency_early", r_valid_o, 0);
    @(posedge CLK); #1;
    req_i = 1'b0;
    @(negedge CLK);
    check("wr_latency_2", r_valid_o, 1);
    wait_rsp(2);
    check("wr_rsp", rsp_q[0], {1'b0, 32'h0});
    check("rd_rsp", rsp_q[1], {1'b0, 32'h0000_BEEF});

    // 3. back-to-back reads of words 0..7
    for (int i = 0; i < 8; i++) mem[i] = 32'hA500_0000 | i;
    rsp_q.delete(); rsp_cyc.delete();
    gcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      drive(1, 0, 17'(i * 4), 4'hF, 32'h0);
      @(negedge CLK);
      if (gnt_o) gcnt++;
    end
    @(posedge CLK); #1;
    req_i = 1'b0;
    check("b2b_grants", 64'(gcnt), 64'd8);
    wait_rsp(8);
    for (int i = 0; i < 8; i++) check("b2b_rsp", rsp_q[i], {1'b0, 32'hA500_0000 | i});
    check("b2b_spacing", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'd7);

    // 4. backpressure: only RSP_DEPTH grants, held data, resume in the same cycle
    for (int i = 0; i < 4; i++) mem[10 + i] = 32'h1111_0000 + i;
    rsp_q.delete(); rsp_cyc.delete();
    @(posedge CLK); #1;
    r_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      drive(1, 0, 17'((10 + k) * 4), 4'hF, 32'h0);
      @(negedge CLK);
      if (gnt_o) k++;
    end
    check("bp_grants", 64'(k), 64'd2);
    check("bp_gnt_low", gnt_o, 0);
    check("bp_valid", r_valid_o, 1);
    check("bp_rdata", r_rdata_o, 32'h1111_0000);
    repeat (2) @(negedge CLK);
    check("bp_hold_rdata", r_rdata_o, 32'h1111_0000);
    check("bp_hold_opc", r_opc_o, 0);
    @(posedge CLK); #1;
    r_ready_i = 1'b1;
    @(negedge CLK);
    check("bp_resume", gnt_o, 1);
    if (gnt_o) k++;
    for (int c = 0; c < 10 && k < 4; c++) begin
      @(posedge CLK); #1;
      drive(1, 0, 17'((10 + k) * 4), 4'hF, 32'h0);
      @(negedge CLK);
      if (gnt_o) k++;
    end
    @(posedge CLK); #1;
    req_i = 1'b0;
    wait_rsp(4);
    for (int i = 0; i < 4; i++) check("bp_rsp", rsp_q[i], {1'b0, 32'h1111_0000 + i});

    // 5. out-of-range accesses and the last valid word
    rsp_q.delete(); rsp_cyc.delete();
    @(posedge CLK); #1;
    drive(1, 0, 17'h1C000, 4'hF, 32'h0);
    @(negedge CLK);
    check("oor_rd_gnt", gnt_o, 1);
    check("oor_rd_cen", CEN, 1);
    check("oor_rd_wen", WEN, 1);
    @(posedge CLK); #1;
    drive(1, 1, 17'h1FFFC, 4'hF, 32'hCAFE_F00D);
    @(negedge CLK);
    check("oor_wr_gnt", gnt_o, 1);
    check("oor_wr_cen", CEN, 1);
    @(posedge CLK); #1;
    drive(1, 0, 17'(28671 * 4), 4'hF, 32'h0);
    @(negedge CLK);
    check("last_word_cen", CEN, 0);
    @(posedge CLK); #1;
    drive(1, 0, 17'h100, 4'hF, 32'h0);
    @(negedge CLK);
    check("after_oor_gnt", gnt_o, 1);
    @(posedge CLK); #1;
    req_i = 1'b0;
    wait_rsp(4);
    check("oor_rd_rsp", rsp_q[0], {1'b1, 32'h0});
    check("oor_wr_rsp", rsp_q[1], {1'b1, 32'h0});
    check("last_word_rsp", rsp_q[2], {1'b0, 32'h600D_600D});
    check("after_oor_rsp", rsp_q[3], {1'b0, 32'h0000_BEEF});
    check("oor_wr_no_store", mem[32767], 32'h0);

    // 6. reset with two responses buffered
    rsp_q.delete(); rsp_cyc.delete();
    @(posedge CLK); #1;
    r_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      drive(1, 0, 17'(k * 4), 4'hF, 32'h0);
      @(negedge CLK);
      if (gnt_o) k++;
    end
    check("mid_valid", r_valid_o, 1);
    @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    check("mid_rst_valid", r_valid_o, 0);
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_cen", CEN, 1);
    check("mid_rst_rdata", r_rdata_o, 0);
    @(negedge CLK);
    req_i = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    r_ready_i = 1'b1;
    repeat (5) @(negedge CLK);
    check("mid_no_rsp", 64'(rsp_q.size()), 64'd0);
    @(posedge CLK); #1;
    drive(1, 0, 17'h100, 4'hF, 32'h0);
    @(negedge CLK);
    @(posedge CLK); #1;
    req_i = 1'b0;
    wait_rsp(1);
    check("mid_mem_intact", rsp_q[0], {1'b0, 32'h0000_BEEF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
